// File: rtl/float_print_sequencer.sv
// float_print_sequencer
//
// Prints one signed fixed-point value (scaled by 1e6) as an ASCII frame on a
// byte-wide UART transmitter. The value is latched and handed to an external
// string converter. After one settling cycle, the converter's sign, integer
// digits, fraction digits and range flag are captured into a 16-byte frame
// buffer. The frame is then sent one byte at a time using a tx_start / tx_ready
// handshake.
//
// Frame when in range : sign, integer digits, '.', 6 fraction digits, CR, LF
// Frame when overflow : sign, 'O', 'V', 'F', CR, LF
//
// Parameter
//   SUPPRESS_ZEROS  1: drop leading '0' integer digits (the last one is kept)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   start       print request, only honoured while idle
//   value       signed fixed-point value (x1e6)
//   conv_in     latched value driven to the converter
//   conv_sign   converter sign character ('+' or '-')
//   conv_bfd    six integer ASCII digits, MSD in [47:40]
//   conv_afd    six fraction ASCII digits, MSD in [47:40]
//   conv_valid  converter in-range flag
//   tx_data     byte presented to the transmitter
//   tx_start    one-cycle transmit request
//   tx_ready    transmitter idle flag
//   busy        a frame is in progress
//   done        one-cycle pulse at the end of a frame
module float_print_sequencer #(
  parameter int SUPPRESS_ZEROS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] value,
  output logic [63:0] conv_in,
  input  logic [7:0]  conv_sign,
  input  logic [47:0] conv_bfd,
  input  logic [47:0] conv_afd,
  input  logic        conv_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOAD,
    SEND,
    WAIT_LO,
    WAIT_HI,
    FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] conv_in_reg;
  logic [7:0]  tx_data_reg;
  logic [3:0]  idx_reg;
  logic [4:0]  len_reg;

  logic        latch_en;
  logic        load_en;
  logic        advance_en;
  logic        last_byte;

  logic [7:0]  frame_mem [16];

  // Full-width in-range frame, padded with zeros. Skipping k leading digits
  // becomes a plain k-byte shift of everything after the sign.
  logic [7:0]  full [21];
  logic [7:0]  digit_frame [16];
  logic [7:0]  ovf_frame [16];
  logic [7:0]  load_byte [16];
  logic [4:0]  load_len;
  logic [2:0]  skip_cnt;
  logic        leading;

  assign full[0]  = conv_sign;
  assign full[7]  = 8'h2E;
  assign full[14] = 8'h0D;
  assign full[15] = 8'h0A;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digits
      assign full[1 + gi] = conv_bfd[47 - 8*gi -: 8];
      assign full[8 + gi] = conv_afd[47 - 8*gi -: 8];
    end
    for (genvar gi = 16; gi < 21; gi++) begin : g_pad
      assign full[gi] = 8'h00;
    end
  endgenerate

  // Count leading '0' integer digits. Only the first five are examined, so
  // the units digit is always sent.
  always_comb begin
    skip_cnt = 3'd0;
    leading  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (leading && (full[1 + i] == 8'h30)) begin
        skip_cnt = skip_cnt + 3'd1;
      end else begin
        leading = 1'b0;
      end
    end
    if (SUPPRESS_ZEROS == 0) begin
      skip_cnt = 3'd0;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ovf_frame[i] = 8'h00;
    end
    ovf_frame[0] = conv_sign;
    ovf_frame[1] = 8'h4F;
    ovf_frame[2] = 8'h56;
    ovf_frame[3] = 8'h46;
    ovf_frame[4] = 8'h0D;
    ovf_frame[5] = 8'h0A;
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_frame
      if (gi == 0) begin : g_sign
        assign digit_frame[gi] = full[0];
      end else begin : g_shift
        assign digit_frame[gi] = full[5'(gi) + {2'b00, skip_cnt}];
      end
      assign load_byte[gi] = conv_valid ? digit_frame[gi] : ovf_frame[gi];

      // Frame buffer; read back through the registered tx_data path.
      always_ff @(posedge clk) begin
        if (load_en) begin
          frame_mem[gi] <= load_byte[gi];
        end
      end
    end
  endgenerate

  assign load_len  = conv_valid ? (5'd16 - {2'b00, skip_cnt}) : 5'd6;
  assign last_byte = ({1'b0, idx_reg} == (len_reg - 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      conv_in_reg <= 64'd0;
      tx_data_reg <= 8'h00;
      idx_reg     <= 4'd0;
      len_reg     <= 5'd0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        conv_in_reg <= value;
      end
      if (load_en) begin
        len_reg     <= load_len;
        idx_reg     <= 4'd0;
        tx_data_reg <= load_byte[0];
      end
      if (advance_en) begin
        idx_reg     <= idx_reg + 4'd1;
        tx_data_reg <= frame_mem[idx_reg + 4'd1];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    advance_en = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch_en   = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_start   = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_ready) begin
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_ready) begin
          if (last_byte) begin
            state_next = FIN;
          end else begin
            advance_en = 1'b1;
            state_next = SEND;
          end
        end
      end
      FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign conv_in = conv_in_reg;
  assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_float_print_sequencer.sv
// Bench for float_print_sequencer. It instantiates two copies:
// inst 0 has SUPPRESS_ZEROS=1 and inst 1 has SUPPRESS_ZEROS=0.
// Each copy has its own converter model and UART ready model.
// Expected frames are formatted as strings from the value and queued.
// A negedge monitor pops the queue on every tx_start.
module tb_float_print_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic [63:0]       value;
  logic [1:0][63:0]  conv_in;
  logic [1:0][7:0]   conv_sign;
  logic [1:0][47:0]  conv_bfd;
  logic [1:0][47:0]  conv_afd;
  logic [1:0]        conv_valid;
  logic [1:0][7:0]   tx_data;
  logic [1:0]        tx_start;
  logic [1:0]        tx_ready;
  logic [1:0]        busy;
  logic [1:0]        done;

  logic scramble;
  logic hold;
  int   cnt [2];

  int   checks = 0;
  int   errs = 0;
  int   txn = 0;
  int   done_cnt [2];
  int   frames_exp [2];
  int   bytes_seen [2];
  byte  q0 [$];
  byte  q1 [$];

  function automatic longint mag(logic [63:0] v);
    longint s;
    s = $signed(v);
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [47:0] dig6(longint n);
    logic [47:0] r;
    longint p;
    r = '0;
    p = 100000;
    for (int k = 0; k < 6; k++) begin
      r[47 - 8*k -: 8] = 8'(48 + (n / p) % 10);
      p = p / 10;
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      float_print_sequencer #(.SUPPRESS_ZEROS(gi == 0 ? 1 : 0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .conv_in   (conv_in[gi]),
        .conv_sign (conv_sign[gi]),
        .conv_bfd  (conv_bfd[gi]),
        .conv_afd  (conv_afd[gi]),
        .conv_valid(conv_valid[gi]),
        .tx_data   (tx_data[gi]),
        .tx_start  (tx_start[gi]),
        .tx_ready  (tx_ready[gi]),
        .busy      (busy[gi]),
        .done      (done[gi])
      );
      // The converter model is corrupted by scramble after LOAD. The frame in
      // progress must not notice.
      assign conv_sign[gi]  = (($signed(conv_in[gi]) < 0) ? 8'h2D : 8'h2B) ^ {8{scramble}};
      assign conv_bfd[gi]   = dig6((mag(conv_in[gi]) / 1000000) % 1000000) ^ {48{scramble}};
      assign conv_afd[gi]   = dig6(mag(conv_in[gi]) % 1000000) ^ {48{scramble}};
      assign conv_valid[gi] = (mag(conv_in[gi]) < 64'd1000000000000) ^ scramble;
      assign tx_ready[gi]   = (cnt[gi] == 0) && !hold;
    end
  endgenerate

  // UART model: busy for 1..4 cycles after each tx_start.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) cnt[i] <= 0;
      else if (tx_start[i]) cnt[i] <= int'($urandom_range(1, 4));
      else if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic qpush(int i, byte b);
    if (i == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpop(int i, output byte b);
    if (i == 0) b = q0.pop_front();
    else b = q1.pop_front();
  endtask

  task automatic expect_frame(int i, longint v);
    string  s;
    longint a;
    longint ip;
    longint fp;
    a  = (v < 0) ? -v : v;
    ip = a / 1000000;
    fp = a % 1000000;
    s  = (v < 0) ? "-" : "+";
    if (ip > 999999) s = {s, "OVF"};
    else if (i == 0) s = {s, $sformatf("%0d.%06d", ip, fp)};
    else s = {s, $sformatf("%06d.%06d", ip, fp)};
    for (int k = 0; k < s.len(); k++) qpush(i, s[k]);
    qpush(i, 8'h0D);
    qpush(i, 8'h0A);
    frames_exp[i]++;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    byte e;
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i] === 1'b1) begin
        bytes_seen[i]++;
        if (qsize(i) == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_byte inst=%0d got=%02h required=no byte", i, tx_data[i]);
        end else begin
          qpop(i, e);
          chk($sformatf("byte_inst%0d", i), {56'd0, tx_data[i]}, {56'd0, e});
        end
      end
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        chk($sformatf("done_frame_consumed_inst%0d", i), 64'(qsize(i)), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int c = 0; c < 3000 && busy != 2'b00; c++) @(negedge clk);
    chk("frame_complete", {62'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(longint v, bit hold_test);
    byte sign_b;
    txn++;
    sign_b = (v < 0) ? 8'h2D : 8'h2B;
    for (int i = 0; i < 2; i++) expect_frame(i, v);
    hold = hold_test;
    @(posedge clk); #1;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    value = {$urandom, $urandom};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("conv_in_latched", conv_in[i], v);
      chk("busy_after_start", {63'd0, busy[i]}, 64'd1);
    end
    @(posedge clk);
    @(posedge clk); #1;
    scramble = 1'b1;
    if (hold_test) begin
      repeat (20) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          chk("hold_no_tx_start", {63'd0, tx_start[i]}, 64'd0);
          chk("hold_tx_data_stable", {56'd0, tx_data[i]}, {56'd0, sign_b});
        end
        start = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      hold = 1'b0;
    end else begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("first_tx_start_latency", {63'd0, tx_start[i]}, 64'd1);
        chk("first_byte_sign", {56'd0, tx_data[i]}, {56'd0, sign_b});
      end
    end
    wait_idle();
    scramble = 1'b0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("done_count_inst%0d", i), 64'(done_cnt[i]), 64'(frames_exp[i]));
    $display("txn %0d value=%0d hold=%0d done=%0d/%0d", txn, v, hold_test, done_cnt[0], done_cnt[1]);
  endtask

  task automatic reset_mid(longint v);
    int base;
    txn++;
    for (int i = 0; i < 2; i++) expect_frame(i, v);
    base = bytes_seen[0];
    @(posedge clk); #1;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3000 && bytes_seen[0] < base + 5; c++) @(posedge clk);
    chk("reached_fifth_byte", 64'(bytes_seen[0] >= base + 5), 64'd1);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) frames_exp[i]--;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx_start", {63'd0, tx_start[i]}, 64'd0);
      chk("rst_busy", {63'd0, busy[i]}, 64'd0);
      chk("rst_done", {63'd0, done[i]}, 64'd0);
      chk("rst_tx_data", {56'd0, tx_data[i]}, 64'd0);
      chk("rst_conv_in", conv_in[i], 64'd0);
    end
    $display("txn %0d value=%0d abandoned by reset after byte 5", txn, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    longint ip;
    reset = 1'b1;
    start = 1'b0;
    value = 64'd0;
    scramble = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      frames_exp[i] = 0;
      bytes_seen[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_conv_in", conv_in[i], 64'd0);
      chk("reset_tx_data", {56'd0, tx_data[i]}, 64'd0);
      chk("reset_tx_start", {63'd0, tx_start[i]}, 64'd0);
      chk("reset_busy", {63'd0, busy[i]}, 64'd0);
      chk("reset_done", {63'd0, done[i]}, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    send(64'sd123456789012, 1'b0);
    send(-64'sd1500000, 1'b0);
    send(64'sd0, 1'b0);
    send(64'sd100000000000000, 1'b0);
    send(-64'sd1500000, 1'b1);
    reset_mid(64'sd123456789012);
    send(64'sd2000000, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: ip = longint'($urandom_range(0, 9));
        1: ip = longint'($urandom_range(0, 999999));
        2: ip = longint'($urandom_range(1000000, 5000000));
        default: ip = longint'($urandom_range(0, 999));
      endcase
      v = ip * 1000000 + longint'($urandom_range(0, 999999));
      if ($urandom_range(0, 1) == 1) v = -v;
      send(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/float_print_sequencer.md
FLOAT_PRINT_SEQUENCER -- requirements
Module: float_print_sequencer

Interface
REQ-001 The block SHALL have one parameter: SUPPRESS_ZEROS, default 1, which suppresses leading zeros of the integer field when 1.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to print value; sampled only in IDLE.
- value  in  64  signed two's-complement fixed-point number, scaled by 1e6.
- conv_in  out  64  registered copy of the latched value, driven to the external string converter.
- conv_sign  in  8  converter sign character, 0x2B or 0x2D.
- conv_bfd  in  48  six integer ASCII digits, most significant digit in [47:40].
- conv_afd  in  48  six fraction ASCII digits, most significant digit in [47:40].
- conv_valid  in  1  converter in-range flag.
- tx_data  out  8  byte presented to the UART transmitter.
- tx_start  out  1  one-cycle request to transmit tx_data.
- tx_ready  in  1  UART idle flag.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the frame is complete.

Function
REQ-003 The FSM SHALL have states IDLE, LATCH, LOAD, SEND, WAIT_LO, WAIT_HI and FIN.
REQ-004 In IDLE with start=1, the block SHALL register value into conv_in, set busy=1 and go to LATCH; start SHALL be ignored in all other states.
REQ-005 LATCH SHALL last one cycle to let the converter settle.
REQ-006 LOAD SHALL capture conv_sign, conv_bfd, conv_afd and conv_valid into a 16-byte frame buffer plus a frame length, then go to SEND.
REQ-007 When the captured valid flag is 1, the frame SHALL be: sign, integer digits, 0x2E, six fraction digits, 0x0D, 0x0A (16 bytes maximum).
REQ-008 When SUPPRESS_ZEROS=1, leading 0x30 integer digits SHALL be skipped, but the last integer digit SHALL always be sent.
REQ-009 When the captured valid flag is 0, the frame SHALL be: sign, "OVF" (0x4F 0x56 0x46), 0x0D, 0x0A (6 bytes).
REQ-010 In SEND, tx_data SHALL be the current byte; when tx_ready=1, tx_start SHALL pulse high for exactly one cycle and the FSM SHALL go to WAIT_LO.
REQ-011 In SEND with tx_ready=0, the FSM SHALL hold, with tx_data stable and tx_start low.
REQ-012 WAIT_LO SHALL wait for tx_ready=0.
REQ-013 WAIT_HI SHALL wait for tx_ready=1, then advance the byte index and go to SEND, or go to FIN after the last byte.
REQ-014 tx_data SHALL stay constant from the tx_start pulse until the FSM leaves WAIT_HI.
REQ-015 FIN SHALL assert done for one cycle, clear busy and return to IDLE; a new start SHALL be accepted on the next cycle.
REQ-016 The byte index SHALL be 4 bits, SHALL count from 0 to frame length-1 and SHALL never wrap within a frame.
REQ-017 Latency SHALL be: start sampled at edge N, conv_in valid after edge N, buffer loaded at edge N+2, earliest tx_start in the cycle after edge N+2.
REQ-018 Changes to value or the converter inputs after LOAD SHALL NOT affect the frame in progress.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL force state=IDLE, conv_in=0, tx_data=0, tx_start=0, busy=0, done=0, byte index=0 and frame length=0.
REQ-020 Reset SHALL have priority over start and over every FSM transition.
REQ-021 Reset mid-frame SHALL abandon the frame; the next start SHALL send a complete frame beginning with the sign byte.

Verification
REQ-022 value=123456789012, tx_ready model (low 3 cycles after each pulse) -> 16 bytes "+123456.789012" 0x0D 0x0A, then one done pulse.
REQ-023 value=-1500000, SUPPRESS_ZEROS=1 -> "-1.500000" 0x0D 0x0A (11 bytes); with SUPPRESS_ZEROS=0 -> "-000001.500000" 0x0D 0x0A.
REQ-024 value=0 -> "+0.000000" 0x0D 0x0A; value=100000000000000 (conv_valid=0) -> "+OVF" 0x0D 0x0A, done pulse.
REQ-025 tx_ready held 0 for 20 cycles in SEND -> no tx_start and tx_data unchanged; start pulses while busy -> ignored, exactly one frame sent.
REQ-026 reset asserted after 5th byte -> next edge tx_start=0, busy=0, done=0; a following start with value=2000000 -> "+2.000000" 0x0D 0x0A sent complete.
